// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, the redirect source and decode.
// The master modport is the fetch unit's view; the slave modport is the environment's view.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, small {pc, word} buffer
// in front of decode, and flush/restart on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_word_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, req, grant, push, pop, not_empty;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign not_empty = (count_q != '0);

  // rst_n gates the request so it drops the moment reset is asserted.
  assign req   = rst_n && (state_q == StIdle) && !full && !bus.redirect_valid;
  assign grant = req && bus.imem_gnt;
  assign push  = (state_q == StWait) && bus.imem_rvalid && !bus.redirect_valid;
  assign pop   = not_empty && bus.instr_ready;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = not_empty;
  assign bus.instr       = not_empty ? fifo_word_q[rd_ptr_q] : '0;
  assign bus.instr_pc    = not_empty ? fifo_pc_q[rd_ptr_q] : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
      unique case (state_q)
        StWait:  state_d = bus.imem_rvalid ? StIdle : StDrop;
        StDrop:  state_d = bus.imem_rvalid ? StIdle : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = StWait;
          end
        end
        StWait, StDrop: begin
          if (bus.imem_rvalid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      // A same-cycle pop is consumed by decode; the flush discards everything else.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_word_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_word_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

endmodule
